// File: rtl/axi_rd_mem_slave.sv
// AXI4-Lite read-only responder over an internal 64-bit word memory.
// Single outstanding read, fixed programmable latency, backdoor preload port.
module axi_rd_mem_slave #(
  parameter int                 ADDR_W     = 64,
  parameter int                 DATA_W     = 64,
  parameter int                 DEPTH_LOG2 = 10,
  parameter logic [ADDR_W-1:0]  BASE       = 'h0000_0000_8000_0000,
  parameter int                 LATENCY    = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_W-1:0]     ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_W-1:0]     RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  input  logic                  bd_we,
  input  logic [DEPTH_LOG2-1:0] bd_addr,
  input  logic [DATA_W-1:0]     bd_wdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(64'd8) << DEPTH_LOG2;
  localparam logic [3:0]        CNT_START = 4'(LATENCY - 1);

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_W-1:0]     off;
  logic                  ar_in_range;
  logic                  ar_fire;
  logic [DEPTH_LOG2-1:0] idx_p0;
  logic                  in_range_p0;

  assign ARREADY     = (state == ST_IDLE);
  assign ar_fire     = ARVALID && ARREADY;
  assign off         = ARADDR - BASE;
  // The subtraction wraps for addresses below BASE, so both bounds are needed.
  assign ar_in_range = (ARADDR >= BASE) && (off < SPAN);

  always_ff @(posedge ACLK) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_wdata;
    end
  end

  // Stage p0: address decode captured at the AR handshake
  always_ff @(posedge ACLK) begin
    if (ar_fire) begin
      idx_p0      <= off[DEPTH_LOG2+2:3];
      in_range_p0 <= ar_in_range;
    end
  end

  // Stage p1: latency countdown and registered response
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      RVALID <= 1'b0;
      RDATA  <= '0;
      RRESP  <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ar_fire) begin
            cnt   <= CNT_START;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            // Nonblocking read of mem gives read-before-write against bd_we.
            RDATA  <= in_range_p0 ? mem[idx_p0] : '0;
            RRESP  <= in_range_p0 ? RESP_OKAY : RESP_SLVERR;
            RVALID <= 1'b1;
            state  <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (RREADY) begin
            RVALID <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
